// File: rtl/pipeline_id_hazard.sv
// pipeline_id_hazard
//   Decode stage of the pipelined MIPS core. Decodes one instruction per
//   cycle, reads the architectural register file (with optional same-cycle
//   write-back bypass), detects load-use hazards and registers the decoded
//   bundle into the ID/EX pipeline register.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   if_valid/if_instr/if_pcplus4   instruction from IF
//   ex_flush              kill: ID/EX loads a bubble next edge
//   wb_en/wb_reg/wb_data  register write port from WB
//   id_stall              combinational, IF must hold its outputs
//   ex_*                  ID/EX pipeline register contents
module pipeline_id_hazard #(
  parameter int XLEN   = 32,
  parameter int BYPASS = 1,
  parameter int HAZARD = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pcplus4,
  input  logic            ex_flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_reg,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_stall,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_memtoreg,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic            ex_nez,
  output logic            ex_alusrc,
  output logic            ex_jump,
  output logic            ex_link,
  output logic            ex_jumptoreg,
  output logic            ex_shiftl16,
  output logic            ex_illegal,
  output logic [1:0]      ex_aluop,
  output logic [5:0]      ex_funct,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_dst,
  output logic [XLEN-1:0] ex_rega,
  output logic [XLEN-1:0] ex_regb,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pcplus4
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memtoreg;
    logic            memwrite;
    logic            branch;
    logic            nez;
    logic            alusrc;
    logic            jump;
    logic            link;
    logic            jumptoreg;
    logic            shiftl16;
    logic            illegal;
    logic [1:0]      aluop;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dst;
    logic [XLEN-1:0] rega;
    logic [XLEN-1:0] regb;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pcplus4;
  } id_ex_t;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = if_instr[31:26];
  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign rd     = if_instr[15:11];
  assign funct  = if_instr[5:0];

  // Register file
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];
  logic            wb_hit;

  assign wb_hit = wb_en && (wb_reg != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wb_hit) regs_d[wb_reg] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [XLEN-1:0] rd_a;
  logic [XLEN-1:0] rd_b;

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (rs != 5'd0) begin
      if ((BYPASS != 0) && wb_hit && (wb_reg == rs)) rd_a = wb_data;
      else                                           rd_a = regs_q[rs];
    end
    if (rt != 5'd0) begin
      if ((BYPASS != 0) && wb_hit && (wb_reg == rt)) rd_b = wb_data;
      else                                           rd_b = regs_q[rt];
    end
  end

  // Decode
  id_ex_t dec;
  logic   signext;
  logic   rs_used;
  logic   rt_used;

  always_comb begin
    dec     = '0;
    signext = 1'b0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rs_used   = 1'b1;
        rt_used   = 1'b1;
        dec.aluop = 2'b10;
        if (funct == FN_JR) begin
          dec.jumptoreg = 1'b1;
        end else begin
          dec.regwrite = 1'b1;
          dec.dst      = rd;
        end
      end
      OP_LW: begin
        rs_used      = 1'b1;
        signext      = 1'b1;
        dec.regwrite = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        dec.dst      = rt;
      end
      OP_SW: begin
        rs_used      = 1'b1;
        rt_used      = 1'b1;
        signext      = 1'b1;
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OP_BEQ: begin
        rs_used    = 1'b1;
        rt_used    = 1'b1;
        signext    = 1'b1;
        dec.branch = 1'b1;
        dec.aluop  = 2'b01;
      end
      OP_BNE: begin
        rs_used    = 1'b1;
        rt_used    = 1'b1;
        signext    = 1'b1;
        dec.branch = 1'b1;
        dec.nez    = 1'b1;
        dec.aluop  = 2'b01;
      end
      OP_ADDI: begin
        rs_used      = 1'b1;
        signext      = 1'b1;
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.dst      = rt;
      end
      OP_ORI: begin
        rs_used      = 1'b1;
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = 2'b11;
        dec.dst      = rt;
      end
      OP_LUI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.shiftl16 = 1'b1;
        dec.aluop    = 2'b11;
        dec.dst      = rt;
      end
      OP_J: begin
        dec.jump = 1'b1;
      end
      OP_JAL: begin
        dec.jump     = 1'b1;
        dec.link     = 1'b1;
        dec.regwrite = 1'b1;
        dec.dst      = 5'd31;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    dec.valid   = 1'b1;
    dec.funct   = funct;
    dec.rs      = rs;
    dec.rt      = rt;
    dec.rega    = rd_a;
    dec.regb    = rd_b;
    dec.pcplus4 = if_pcplus4;
    dec.imm     = signext ? {{(XLEN-16){if_instr[15]}}, if_instr[15:0]}
                          : {{(XLEN-16){1'b0}}, if_instr[15:0]};
  end

  // Load-use hazard against the instruction currently in ID/EX
  id_ex_t id_ex_q;
  id_ex_t id_ex_d;
  logic   load_use;

  always_comb begin
    load_use = if_valid && id_ex_q.valid && id_ex_q.memtoreg &&
               (id_ex_q.dst != 5'd0) &&
               ((rs_used && (rs == id_ex_q.dst)) ||
                (rt_used && (rt == id_ex_q.dst)));
  end

  // A flush already bubbles ID/EX, so stalling on top of it would lose a slot.
  assign id_stall = (HAZARD != 0) && load_use && !ex_flush;

  always_comb begin
    if (ex_flush || id_stall || !if_valid) id_ex_d = '0;
    else                                   id_ex_d = dec;
  end

  always_ff @(posedge clk) begin
    if (reset) id_ex_q <= '0;
    else       id_ex_q <= id_ex_d;
  end

  assign ex_valid     = id_ex_q.valid;
  assign ex_regwrite  = id_ex_q.regwrite;
  assign ex_memtoreg  = id_ex_q.memtoreg;
  assign ex_memwrite  = id_ex_q.memwrite;
  assign ex_branch    = id_ex_q.branch;
  assign ex_nez       = id_ex_q.nez;
  assign ex_alusrc    = id_ex_q.alusrc;
  assign ex_jump      = id_ex_q.jump;
  assign ex_link      = id_ex_q.link;
  assign ex_jumptoreg = id_ex_q.jumptoreg;
  assign ex_shiftl16  = id_ex_q.shiftl16;
  assign ex_illegal   = id_ex_q.illegal;
  assign ex_aluop     = id_ex_q.aluop;
  assign ex_funct     = id_ex_q.funct;
  assign ex_rs        = id_ex_q.rs;
  assign ex_rt        = id_ex_q.rt;
  assign ex_dst       = id_ex_q.dst;
  assign ex_rega      = id_ex_q.rega;
  assign ex_regb      = id_ex_q.regb;
  assign ex_imm       = id_ex_q.imm;
  assign ex_pcplus4   = id_ex_q.pcplus4;

endmodule

// File: tb/tb_pipeline_id_hazard.sv
module tb_pipeline_id_hazard;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        branch;
    logic        nez;
    logic        alusrc;
    logic        jump;
    logic        link;
    logic        jumptoreg;
    logic        shiftl16;
    logic        illegal;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rega;
    logic [31:0] regb;
    logic [31:0] imm;
    logic [31:0] pc;
  } ex_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pcplus4;
  logic        ex_flush;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  logic        id_stall, ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_branch;
  logic        ex_nez, ex_alusrc, ex_jump, ex_link, ex_jumptoreg, ex_shiftl16, ex_illegal;
  logic [1:0]  ex_aluop;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [31:0] ex_rega, ex_regb, ex_imm, ex_pcplus4;

  logic        nb_id_stall, nb_ex_valid, nb_ex_regwrite, nb_ex_memtoreg, nb_ex_memwrite, nb_ex_branch;
  logic        nb_ex_nez, nb_ex_alusrc, nb_ex_jump, nb_ex_link, nb_ex_jumptoreg, nb_ex_shiftl16, nb_ex_illegal;
  logic [1:0]  nb_ex_aluop;
  logic [5:0]  nb_ex_funct;
  logic [4:0]  nb_ex_rs, nb_ex_rt, nb_ex_dst;
  logic [31:0] nb_ex_rega, nb_ex_regb, nb_ex_imm, nb_ex_pcplus4;

  always #5 clk = ~clk;

  pipeline_id_hazard #(.XLEN(32), .BYPASS(1), .HAZARD(1)) u_dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_pcplus4(if_pcplus4), .ex_flush(ex_flush), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_nez(ex_nez), .ex_alusrc(ex_alusrc), .ex_jump(ex_jump),
    .ex_link(ex_link), .ex_jumptoreg(ex_jumptoreg), .ex_shiftl16(ex_shiftl16),
    .ex_illegal(ex_illegal), .ex_aluop(ex_aluop), .ex_funct(ex_funct), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_rega(ex_rega), .ex_regb(ex_regb),
    .ex_imm(ex_imm), .ex_pcplus4(ex_pcplus4)
  );

  // No bypass, no hazard detection; shares the stimulus of the main instance.
  pipeline_id_hazard #(.XLEN(32), .BYPASS(0), .HAZARD(0)) u_dut_nb (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_pcplus4(if_pcplus4), .ex_flush(ex_flush), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .id_stall(nb_id_stall), .ex_valid(nb_ex_valid),
    .ex_regwrite(nb_ex_regwrite), .ex_memtoreg(nb_ex_memtoreg), .ex_memwrite(nb_ex_memwrite),
    .ex_branch(nb_ex_branch), .ex_nez(nb_ex_nez), .ex_alusrc(nb_ex_alusrc), .ex_jump(nb_ex_jump),
    .ex_link(nb_ex_link), .ex_jumptoreg(nb_ex_jumptoreg), .ex_shiftl16(nb_ex_shiftl16),
    .ex_illegal(nb_ex_illegal), .ex_aluop(nb_ex_aluop), .ex_funct(nb_ex_funct), .ex_rs(nb_ex_rs),
    .ex_rt(nb_ex_rt), .ex_dst(nb_ex_dst), .ex_rega(nb_ex_rega), .ex_regb(nb_ex_regb),
    .ex_imm(nb_ex_imm), .ex_pcplus4(nb_ex_pcplus4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_regs [32];
  ex_t         m_ex;
  logic        model_known = 1'b0;
  ex_t         sb_q [$];
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic        seen_stall;
  logic        seen_nb_stall;

  // Control table: {regwrite,memtoreg,memwrite,branch,nez,alusrc,jump,link,
  //                 jumptoreg,shiftl16,illegal | signext | aluop | rs_used rt_used | dst_sel}
  // dst_sel: 0 none, 1 rd, 2 rt, 3 r31
  function automatic ex_t ref_dec(input logic [31:0] ins, output logic urs, output logic urt);
    logic [17:0] c;
    ex_t e;
    case (ins[31:26])
      6'b000000: c = (ins[5:0] == 6'b001000) ? 18'b00000000100_0_10_11_00
                                             : 18'b10000000000_0_10_11_01;
      6'b100011: c = 18'b11000100000_1_00_10_10;
      6'b101011: c = 18'b00100100000_1_00_11_00;
      6'b000100: c = 18'b00010000000_1_01_11_00;
      6'b000101: c = 18'b00011000000_1_01_11_00;
      6'b001000: c = 18'b10000100000_1_00_10_10;
      6'b001101: c = 18'b10000100000_0_11_10_10;
      6'b001111: c = 18'b10000100010_0_11_00_10;
      6'b000010: c = 18'b00000010000_0_00_00_00;
      6'b000011: c = 18'b10000011000_0_00_00_11;
      default:   c = 18'b00000000001_0_00_00_00;
    endcase
    e = '0;
    e.valid     = 1'b1;
    e.regwrite  = c[17];
    e.memtoreg  = c[16];
    e.memwrite  = c[15];
    e.branch    = c[14];
    e.nez       = c[13];
    e.alusrc    = c[12];
    e.jump      = c[11];
    e.link      = c[10];
    e.jumptoreg = c[9];
    e.shiftl16  = c[8];
    e.illegal   = c[7];
    e.aluop     = c[5:4];
    urs         = c[3];
    urt         = c[2];
    case (c[1:0])
      2'd1:    e.dst = ins[15:11];
      2'd2:    e.dst = ins[20:16];
      2'd3:    e.dst = 5'd31;
      default: e.dst = 5'd0;
    endcase
    e.funct = ins[5:0];
    e.rs    = ins[25:21];
    e.rt    = ins[20:16];
    e.imm   = c[6] ? {{16{ins[15]}}, ins[15:0]} : {16'h0000, ins[15:0]};
    return e;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_en && wb_reg == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic ex_t dut_bundle();
    ex_t e;
    e.valid = ex_valid; e.regwrite = ex_regwrite; e.memtoreg = ex_memtoreg;
    e.memwrite = ex_memwrite; e.branch = ex_branch; e.nez = ex_nez;
    e.alusrc = ex_alusrc; e.jump = ex_jump; e.link = ex_link;
    e.jumptoreg = ex_jumptoreg; e.shiftl16 = ex_shiftl16; e.illegal = ex_illegal;
    e.aluop = ex_aluop; e.funct = ex_funct; e.rs = ex_rs; e.rt = ex_rt; e.dst = ex_dst;
    e.rega = ex_rega; e.regb = ex_regb; e.imm = ex_imm; e.pc = ex_pcplus4;
    return e;
  endfunction

  // Scoreboard consumer: compare the ID/EX register just after each edge.
  always @(posedge clk) begin
    ex_t exp_e;
    #1;
    if (sb_q.size() > 0) begin
      exp_e = sb_q.pop_front();
      check_eq("ex_bundle", dut_bundle(), exp_e);
    end
  end

  // One cycle: drive at the falling edge, predict, then wait past the rising edge.
  task automatic cyc(input logic rst, input logic v, input logic [31:0] ins,
                     input logic fl, input logic we, input logic [4:0] wr,
                     input logic [31:0] wd);
    ex_t  d, nxt;
    logic urs, urt, haz, stall;
    @(negedge clk);
    reset = rst; if_valid = v; if_instr = ins; if_pcplus4 = pc_ctr;
    ex_flush = fl; wb_en = we; wb_reg = wr; wb_data = wd;
    pc_ctr = pc_ctr + 32'd4;
    #1;
    d      = ref_dec(ins, urs, urt);
    d.rega = m_read(ins[25:21]);
    d.regb = m_read(ins[20:16]);
    d.pc   = if_pcplus4;
    haz = v && m_ex.valid && m_ex.memtoreg && (m_ex.dst != 5'd0) &&
          ((urs && ins[25:21] == m_ex.dst) || (urt && ins[20:16] == m_ex.dst));
    stall = haz && !fl;
    seen_stall    = id_stall;
    seen_nb_stall = nb_id_stall;
    if (model_known) check_eq("id_stall", id_stall, stall);
    nxt = (rst || fl || stall || !v) ? '0 : d;
    sb_q.push_back(nxt);
    m_ex = nxt;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      model_known = 1'b1;
    end else if (we && wr != 5'd0) begin
      m_regs[wr] = wd;
    end
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] I_NOP    = 32'h0000_0020;
  localparam logic [31:0] I_ADDI1  = 32'h2001_0005;
  localparam logic [31:0] I_ADD320 = 32'h0040_1820;
  localparam logic [31:0] I_LW4    = 32'h8C04_0000;
  localparam logic [31:0] I_ADD544 = 32'h0084_2820;
  localparam logic [31:0] I_LW0    = 32'h8C00_0000;
  localparam logic [31:0] I_ADD500 = 32'h0000_2820;
  localparam logic [31:0] I_LUI4   = 32'h3C04_1234;
  localparam logic [31:0] I_ORI6   = 32'h3406_8000;
  localparam logic [31:0] I_ADDI7  = 32'h2007_8000;
  localparam logic [31:0] I_ILL    = 32'hFC00_0000;
  localparam logic [31:0] I_JAL    = 32'h0C00_0010;

  logic [31:0] rnd_tab [12];

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pcplus4 = '0;
    ex_flush = 1'b0; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    m_ex = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    rnd_tab = '{32'h8C24_0004, 32'h0081_2820, 32'hAC24_0004, 32'h1022_FFFF,
                32'h1422_FFFF, 32'h2023_8001, 32'h3463_00F0, 32'h3C05_ABCD,
                32'h0800_0004, 32'h03E0_0008, 32'h0C00_0010, 32'h7C00_0000};

    cyc(1, 0, I_NOP, 0, 0, 0, 0);
    cyc(1, 1, I_ADDI1, 0, 0, 0, 0);
    check_eq("rst_valid", ex_valid, 1'b0);
    check_eq("rst_stall", id_stall, 1'b0);

    cyc(0, 1, I_ADDI1, 0, 0, 0, 0);
    check_eq("addi_valid", ex_valid, 1'b1);
    check_eq("addi_regwrite", ex_regwrite, 1'b1);
    check_eq("addi_alusrc", ex_alusrc, 1'b1);
    check_eq("addi_imm", ex_imm, 32'd5);
    check_eq("addi_dst", ex_dst, 5'd1);

    // Same-cycle write-back of $2 while reading $2
    cyc(0, 1, I_ADD320, 0, 1, 5'd2, 32'hDEAD_BEEF);
    check_eq("bypass_on", ex_rega, 32'hDEAD_BEEF);
    check_eq("bypass_off", nb_ex_rega, 32'h0);
    cyc(0, 1, I_ADD320, 0, 0, 0, 0);
    check_eq("bypass_off_commit", nb_ex_rega, 32'hDEAD_BEEF);

    // Writes to $0 are dropped
    cyc(0, 1, I_NOP, 0, 1, 5'd0, 32'h5555_5555);
    cyc(0, 1, I_ADD500, 0, 0, 0, 0);
    check_eq("r0_zero", ex_rega, 32'h0);

    // Load-use: one stall cycle, one bubble
    cyc(0, 1, I_LW4, 0, 0, 0, 0);
    cyc(0, 1, I_ADD544, 0, 0, 0, 0);
    check_eq("lu_stall", seen_stall, 1'b1);
    check_eq("lu_nohaz_stall", seen_nb_stall, 1'b0);
    check_eq("lu_bubble", ex_valid, 1'b0);
    cyc(0, 1, I_ADD544, 0, 0, 0, 0);
    check_eq("lu_stall_drop", seen_stall, 1'b0);
    check_eq("lu_add_valid", ex_valid, 1'b1);
    check_eq("lu_add_rs", ex_rs, 5'd4);
    check_eq("lu_add_rt", ex_rt, 5'd4);

    // No hazard through $0 or against a non-reading lui
    cyc(0, 1, I_LW0, 0, 0, 0, 0);
    cyc(0, 1, I_ADD500, 0, 0, 0, 0);
    check_eq("lw0_nostall", seen_stall, 1'b0);
    cyc(0, 1, I_LW4, 0, 0, 0, 0);
    cyc(0, 1, I_LUI4, 0, 0, 0, 0);
    check_eq("lui_nostall", seen_stall, 1'b0);
    check_eq("lui_shift", ex_shiftl16, 1'b1);

    // Flush during hazard
    cyc(0, 1, I_LW4, 0, 0, 0, 0);
    cyc(0, 1, I_ADD544, 1, 0, 0, 0);
    check_eq("flush_nostall", seen_stall, 1'b0);
    check_eq("flush_bubble", ex_valid, 1'b0);
    cyc(0, 1, I_ADD544, 0, 0, 0, 0);
    check_eq("flush_next_valid", ex_valid, 1'b1);

    // Immediate extension and special opcodes
    cyc(0, 1, I_ORI6, 0, 0, 0, 0);
    check_eq("ori_imm", ex_imm, 32'h0000_8000);
    cyc(0, 1, I_ADDI7, 0, 0, 0, 0);
    check_eq("addi_simm", ex_imm, 32'hFFFF_8000);
    cyc(0, 1, I_ILL, 0, 0, 0, 0);
    check_eq("ill_flag", ex_illegal, 1'b1);
    check_eq("ill_regwrite", ex_regwrite, 1'b0);
    check_eq("ill_valid", ex_valid, 1'b1);
    cyc(0, 1, I_JAL, 0, 0, 0, 0);
    check_eq("jal_dst", ex_dst, 5'd31);
    check_eq("jal_link", ex_link, 1'b1);

    // Invalid slot
    cyc(0, 0, I_ADDI1, 0, 0, 0, 0);
    check_eq("invalid_bubble", ex_valid, 1'b0);

    // Reset while stalling
    cyc(0, 1, I_LW4, 0, 0, 0, 0);
    cyc(1, 1, I_ADD544, 0, 0, 0, 0);
    check_eq("rststall_stall", seen_stall, 1'b1);
    check_eq("rststall_clear", ex_valid, 1'b0);
    cyc(0, 1, I_ADD544, 0, 0, 0, 0);
    check_eq("rststall_drop", seen_stall, 1'b0);

    // Mixed traffic against the model
    for (int k = 0; k < 40; k++) begin
      cyc(0, ($urandom_range(0, 7) != 0), rnd_tab[$urandom_range(0, 11)],
          ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
          5'($urandom_range(0, 7)), $urandom);
    end
    cyc(0, 0, I_NOP, 0, 0, 0, 0);

    check_eq("sb_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
